// File: rtl/mem_region_pkg.sv
// Shared types and default memory map for the CPU memory-region decoder.
package mem_region_pkg;

  localparam logic [63:0] DEF_IM_BOTTOM = 64'h0000_0000_0000_1F00;
  localparam logic [63:0] DEF_IM_TOP    = 64'h0000_0007_FFFF_FFFF;
  localparam logic [63:0] DEF_DM_BOTTOM = 64'h0000_0008_0000_0000;
  localparam logic [63:0] DEF_DM_TOP    = 64'h0000_000F_FFFF_FFFF;

  typedef enum logic [2:0] {
    IDLE, DECODE, ISSUE_IM, ISSUE_DM, WAIT_IM, WAIT_DM, RESP, ERR
  } state_e;

  typedef enum logic [1:0] {
    REG_IM, REG_DM, REG_NONE
  } region_e;

  // IM has priority on overlap; a write landing in IM is a fault even if DM also covers it.
  function automatic region_e classify(input logic im_hit, input logic dm_hit, input logic we);
    region_e r;
    if (im_hit)      r = we ? REG_NONE : REG_IM;
    else if (dm_hit) r = REG_DM;
    else             r = REG_NONE;
    return r;
  endfunction

endpackage

// File: rtl/mem_region_match.sv
// Inclusive window compare and window-relative offset for one memory region.
module mem_region_match
  import mem_region_pkg::*;
#(
  parameter int ADDR_W = 64
) (
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [ADDR_W-1:0] i_bottom,
  input  logic [ADDR_W-1:0] i_top,
  output logic              o_hit,
  output logic [ADDR_W-1:0] o_offset
);

  assign o_hit    = (i_addr >= i_bottom) && (i_addr <= i_top);
  assign o_offset = i_addr - i_bottom;

endmodule

// File: rtl/cpu_mem_region_decoder.sv
// Routes CPU memory requests to the IM or DM port as window-relative offsets, or faults them.
// Optional fault logging (fault_count, fault_addr) is enabled by CPU_MEM_REGION_FAULT_LOG_EN.
//
// state    | meaning
// IDLE     | waiting for a request; applies bound loads
// DECODE   | classify captured address against the windows
// ISSUE_IM | im_req_valid held until im_req_ready
// ISSUE_DM | dm_req_valid held until dm_req_ready
// WAIT_IM  | waiting for im_rsp_valid
// WAIT_DM  | waiting for dm_rsp_valid
// RESP     | one-cycle good response
// ERR      | one-cycle error response, sets fault
module cpu_mem_region_decoder
  import mem_region_pkg::*;
#(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic [ADDR_W-1:0] i_im_bottom,
  input  logic [ADDR_W-1:0] i_im_top,
  input  logic [ADDR_W-1:0] i_dm_bottom,
  input  logic [ADDR_W-1:0] i_dm_top,
  input  logic              i_cfg_load,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic [ADDR_W-1:0] i_req_addr,
  input  logic              i_req_we,
  input  logic [DATA_W-1:0] i_req_wdata,
  output logic              o_rsp_valid,
  output logic [DATA_W-1:0] o_rsp_rdata,
  output logic              o_rsp_err,
  output logic              o_im_req_valid,
  input  logic              i_im_req_ready,
  output logic [ADDR_W-1:0] o_im_req_addr,
  input  logic              i_im_rsp_valid,
  input  logic [DATA_W-1:0] i_im_rsp_rdata,
  output logic              o_dm_req_valid,
  input  logic              i_dm_req_ready,
  output logic [ADDR_W-1:0] o_dm_req_addr,
  output logic              o_dm_req_we,
  output logic [DATA_W-1:0] o_dm_req_wdata,
  input  logic              i_dm_rsp_valid,
  input  logic [DATA_W-1:0] i_dm_rsp_rdata,
`ifdef CPU_MEM_REGION_FAULT_LOG_EN
  output logic [15:0]       o_fault_count,
  output logic [ADDR_W-1:0] o_fault_addr,
`endif
  output logic              o_fault,
  input  logic              i_fault_clr
);

  state_e            r_state;
  logic [ADDR_W-1:0] r_im_bottom, r_im_top, r_dm_bottom, r_dm_top;
  logic              r_bounds_valid, r_pending_load;
  logic [ADDR_W-1:0] r_addr, r_im_req_addr, r_dm_req_addr;
  logic              r_we, r_dm_we, r_fault;
  logic [DATA_W-1:0] r_wdata, r_dm_wdata, r_rdata;

  logic              w_im_hit, w_dm_hit, w_accept, w_load;
  logic [ADDR_W-1:0] w_im_off, w_dm_off;
  region_e           w_region;

  mem_region_match #(.ADDR_W(ADDR_W)) u_match_im (
    .i_addr(r_addr), .i_bottom(r_im_bottom), .i_top(r_im_top),
    .o_hit(w_im_hit), .o_offset(w_im_off)
  );

  mem_region_match #(.ADDR_W(ADDR_W)) u_match_dm (
    .i_addr(r_addr), .i_bottom(r_dm_bottom), .i_top(r_dm_top),
    .o_hit(w_dm_hit), .o_offset(w_dm_off)
  );

  assign w_region    = classify(w_im_hit, w_dm_hit, r_we);
  assign o_req_ready = (r_state == IDLE) && r_bounds_valid && !r_pending_load;
  assign w_accept    = i_req_valid && o_req_ready;
  // A load deferred while busy lands on the first IDLE cycle with the bounds present then.
  assign w_load      = (r_state == IDLE) && (i_cfg_load || r_pending_load);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state        <= IDLE;
      r_im_bottom    <= ADDR_W'(DEF_IM_BOTTOM);
      r_im_top       <= ADDR_W'(DEF_IM_TOP);
      r_dm_bottom    <= ADDR_W'(DEF_DM_BOTTOM);
      r_dm_top       <= ADDR_W'(DEF_DM_TOP);
      r_bounds_valid <= 1'b0;
      r_pending_load <= 1'b0;
      r_addr         <= '0;
      r_we           <= 1'b0;
      r_wdata        <= '0;
      r_im_req_addr  <= '0;
      r_dm_req_addr  <= '0;
      r_dm_we        <= 1'b0;
      r_dm_wdata     <= '0;
      r_rdata        <= '0;
      r_fault        <= 1'b0;
    end else begin
      if (w_load) begin
        r_im_bottom    <= i_im_bottom;
        r_im_top       <= i_im_top;
        r_dm_bottom    <= i_dm_bottom;
        r_dm_top       <= i_dm_top;
        r_bounds_valid <= 1'b1;
        r_pending_load <= 1'b0;
      end else if (i_cfg_load) begin
        r_pending_load <= 1'b1;
      end

      if (r_state == ERR)   r_fault <= 1'b1;
      else if (i_fault_clr) r_fault <= 1'b0;

      case (r_state)
        IDLE: if (w_accept) begin
          r_addr  <= i_req_addr;
          r_we    <= i_req_we;
          r_wdata <= i_req_wdata;
          r_state <= DECODE;
        end
        DECODE: begin
          case (w_region)
            REG_IM: begin
              r_im_req_addr <= w_im_off;
              r_state       <= ISSUE_IM;
            end
            REG_DM: begin
              r_dm_req_addr <= w_dm_off;
              r_dm_we       <= r_we;
              r_dm_wdata    <= r_wdata;
              r_state       <= ISSUE_DM;
            end
            default: r_state <= ERR;
          endcase
        end
        ISSUE_IM: if (i_im_req_ready) r_state <= WAIT_IM;
        ISSUE_DM: if (i_dm_req_ready) r_state <= WAIT_DM;
        WAIT_IM: if (i_im_rsp_valid) begin
          r_rdata <= i_im_rsp_rdata;
          r_state <= RESP;
        end
        WAIT_DM: if (i_dm_rsp_valid) begin
          r_rdata <= i_dm_rsp_rdata;
          r_state <= RESP;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

`ifdef CPU_MEM_REGION_FAULT_LOG_EN
  logic [15:0]       r_fault_count;
  logic [ADDR_W-1:0] r_fault_addr;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_fault_count <= '0;
      r_fault_addr  <= '0;
    end else if (r_state == ERR) begin
      if (r_fault_count != 16'hFFFF) r_fault_count <= r_fault_count + 16'd1;
      r_fault_addr <= r_addr;
    end
  end

  assign o_fault_count = r_fault_count;
  assign o_fault_addr  = r_fault_addr;
`endif

  assign o_rsp_valid    = (r_state == RESP) || (r_state == ERR);
  assign o_rsp_err      = (r_state == ERR);
  assign o_rsp_rdata    = (r_state == RESP) ? r_rdata : '0;
  assign o_im_req_valid = (r_state == ISSUE_IM);
  assign o_im_req_addr  = r_im_req_addr;
  assign o_dm_req_valid = (r_state == ISSUE_DM);
  assign o_dm_req_addr  = r_dm_req_addr;
  assign o_dm_req_we    = r_dm_we;
  assign o_dm_req_wdata = r_dm_wdata;
  assign o_fault        = r_fault;

endmodule

// File: tb/tb_cpu_mem_region_decoder.sv
// Directed scoreboard bench for cpu_mem_region_decoder.
module tb_cpu_mem_region_decoder;

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] im_bottom, im_top, dm_bottom, dm_top;
  logic        cfg_load, req_valid, req_ready, req_we;
  logic [63:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_err;
  logic [63:0] rsp_rdata;
  logic        im_req_valid, im_req_ready, im_rsp_valid;
  logic [63:0] im_req_addr, im_rsp_rdata;
  logic        dm_req_valid, dm_req_ready, dm_req_we, dm_rsp_valid;
  logic [63:0] dm_req_addr, dm_req_wdata, dm_rsp_rdata;
  logic        fault, fault_clr;
`ifdef CPU_MEM_REGION_FAULT_LOG_EN
  logic [15:0] fault_count;
  logic [63:0] fault_addr;
`endif

  cpu_mem_region_decoder #(.ADDR_W(64), .DATA_W(64)) dut (
    .i_clk(clk), .i_reset(reset),
    .i_im_bottom(im_bottom), .i_im_top(im_top), .i_dm_bottom(dm_bottom), .i_dm_top(dm_top),
    .i_cfg_load(cfg_load),
    .i_req_valid(req_valid), .o_req_ready(req_ready), .i_req_addr(req_addr),
    .i_req_we(req_we), .i_req_wdata(req_wdata),
    .o_rsp_valid(rsp_valid), .o_rsp_rdata(rsp_rdata), .o_rsp_err(rsp_err),
    .o_im_req_valid(im_req_valid), .i_im_req_ready(im_req_ready), .o_im_req_addr(im_req_addr),
    .i_im_rsp_valid(im_rsp_valid), .i_im_rsp_rdata(im_rsp_rdata),
    .o_dm_req_valid(dm_req_valid), .i_dm_req_ready(dm_req_ready), .o_dm_req_addr(dm_req_addr),
    .o_dm_req_we(dm_req_we), .o_dm_req_wdata(dm_req_wdata),
    .i_dm_rsp_valid(dm_rsp_valid), .i_dm_rsp_rdata(dm_rsp_rdata),
`ifdef CPU_MEM_REGION_FAULT_LOG_EN
    .o_fault_count(fault_count), .o_fault_addr(fault_addr),
`endif
    .o_fault(fault), .i_fault_clr(fault_clr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        err;
    logic [63:0] rdata;
  } exp_t;

  exp_t sbq[$];
  int total = 0;
  int bad = 0;
  int cyc = 0;
  int acc_cyc = 0;
  int last_rsp_cyc = 0;
  int rsp_cnt = 0;
  int im_v_cnt = 0;
  int dm_v_cnt = 0;
  int snap_rsp, snap_im, snap_dm;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rsp_valid === 1'b1) begin
      exp_t e;
      rsp_cnt++;
      last_rsp_cyc = cyc;
      if (sbq.size() == 0) begin
        chk("unexpected_rsp", 64'(rsp_valid), 64'd0);
      end else begin
        e = sbq.pop_front();
        chk("rsp_err", 64'(rsp_err), 64'(e.err));
        chk("rsp_rdata", rsp_rdata, e.rdata);
      end
    end
    if (im_req_valid === 1'b1) im_v_cnt++;
    if (dm_req_valid === 1'b1) dm_v_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic err, input logic [63:0] rd);
    exp_t e;
    e.err = err;
    e.rdata = rd;
    sbq.push_back(e);
  endtask

  task automatic send(input logic [63:0] a, input logic we, input logic [63:0] wd);
    chk("req_ready_before_send", 64'(req_ready), 64'd1);
    req_valid = 1'b1; req_addr = a; req_we = we; req_wdata = wd;
    acc_cyc = cyc;
    tick();
    req_valid = 1'b0;
  endtask

  task automatic set_default_bounds();
    im_bottom = 64'h1F00;          im_top = 64'h7_FFFF_FFFF;
    dm_bottom = 64'h8_0000_0000;   dm_top = 64'hF_FFFF_FFFF;
  endtask

  initial begin
    reset = 1'b1; cfg_load = 1'b0; req_valid = 1'b0; req_we = 1'b0;
    req_addr = '0; req_wdata = '0; im_req_ready = 1'b0; im_rsp_valid = 1'b0;
    im_rsp_rdata = '0; dm_req_ready = 1'b0; dm_rsp_valid = 1'b0; dm_rsp_rdata = '0;
    fault_clr = 1'b0;
    set_default_bounds();
    repeat (3) tick();
    reset = 1'b0;
    tick();

    // reset values
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_im_valid", 64'(im_req_valid), 64'd0);
    chk("rst_dm_valid", 64'(dm_req_valid), 64'd0);
    chk("rst_fault", 64'(fault), 64'd0);
    chk("rst_im_addr", im_req_addr, 64'd0);
    chk("rst_dm_addr", dm_req_addr, 64'd0);
    chk("rst_rsp_rdata", rsp_rdata, 64'd0);
`ifdef CPU_MEM_REGION_FAULT_LOG_EN
    chk("rst_fault_count", 64'(fault_count), 64'd0);
`endif

    // requests before any cfg_load are never accepted
    req_valid = 1'b1; req_addr = 64'h1F00; req_we = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("no_cfg_req_ready", 64'(req_ready), 64'd0);
      tick();
    end
    req_valid = 1'b0;
    chk("no_cfg_no_rsp", 64'(rsp_cnt), 64'd0);

    cfg_load = 1'b1; tick(); cfg_load = 1'b0;
    chk("cfg_req_ready", 64'(req_ready), 64'd1);

    // IM read at bottom, minimum latency
    im_req_ready = 1'b1;
    push(1'b0, 64'hDEAD);
    send(64'h1F00, 1'b0, 64'd0);
    tick();
    chk("im_valid_n2", 64'(im_req_valid), 64'd1);
    chk("im_addr_bottom", im_req_addr, 64'h0);
    tick();
    im_rsp_valid = 1'b1; im_rsp_rdata = 64'hDEAD;
    tick();
    im_rsp_valid = 1'b0;
    tick();
    chk("hit_latency", 64'(last_rsp_cyc - acc_cyc), 64'd4);
    im_req_ready = 1'b0;

    // DM write with back-pressure
    snap_rsp = rsp_cnt; snap_dm = dm_v_cnt;
    push(1'b0, 64'h77);
    send(64'h8_0000_0010, 1'b1, 64'h55);
    tick();
    for (int i = 0; i < 4; i++) begin
      if (i == 3) dm_req_ready = 1'b1;
      chk("dm_valid_hold", 64'(dm_req_valid), 64'd1);
      chk("dm_addr_hold", dm_req_addr, 64'h10);
      chk("dm_we_hold", 64'(dm_req_we), 64'd1);
      chk("dm_wdata_hold", dm_req_wdata, 64'h55);
      tick();
    end
    dm_req_ready = 1'b0;
    dm_rsp_valid = 1'b1; dm_rsp_rdata = 64'h77;
    tick();
    dm_rsp_valid = 1'b0;
    tick();
    chk("dm_single_rsp", 64'(rsp_cnt - snap_rsp), 64'd1);
    chk("dm_valid_cycles", 64'(dm_v_cnt - snap_dm), 64'd4);

    // IM write and out-of-map read both fault
    snap_im = im_v_cnt; snap_dm = dm_v_cnt;
    push(1'b1, 64'd0);
    send(64'h2000, 1'b1, 64'hAA);
    tick();
    chk("err_pulse_n2", 64'(rsp_valid), 64'd1);
    chk("err_pulse_err", 64'(rsp_err), 64'd1);
    tick();
    chk("fault_after_im_wr", 64'(fault), 64'd1);
    push(1'b1, 64'd0);
    send(64'h10_0000_0000, 1'b0, 64'd0);
    tick(); tick();
    chk("fault_sticky", 64'(fault), 64'd1);
    chk("err_no_im_valid", 64'(im_v_cnt - snap_im), 64'd0);
    chk("err_no_dm_valid", 64'(dm_v_cnt - snap_dm), 64'd0);
`ifdef CPU_MEM_REGION_FAULT_LOG_EN
    chk("fault_count_2", 64'(fault_count), 64'd2);
    chk("fault_addr_oom", fault_addr, 64'h10_0000_0000);
`endif
    fault_clr = 1'b1; tick(); fault_clr = 1'b0;
    chk("fault_cleared", 64'(fault), 64'd0);

    // boundaries: IM top hit, just below IM bottom faults (with fault_clr held: set wins)
    im_req_ready = 1'b1;
    push(1'b0, 64'hBEEF);
    send(64'h7_FFFF_FFFF, 1'b0, 64'd0);
    tick();
    chk("im_top_offset", im_req_addr, 64'h7_FFFF_E0FF);
    tick();
    im_rsp_valid = 1'b1; im_rsp_rdata = 64'hBEEF;
    tick();
    im_rsp_valid = 1'b0;
    tick();
    im_req_ready = 1'b0;
    fault_clr = 1'b1;
    push(1'b1, 64'd0);
    send(64'h1EFF, 1'b0, 64'd0);
    tick(); tick();
    fault_clr = 1'b0;
    chk("fault_set_wins", 64'(fault), 64'd1);
`ifdef CPU_MEM_REGION_FAULT_LOG_EN
    chk("fault_count_3", 64'(fault_count), 64'd3);
    chk("fault_addr_1eff", fault_addr, 64'h1EFF);
`endif

    // cfg_load during WAIT_DM is deferred until after RESP
    dm_req_ready = 1'b1;
    push(1'b0, 64'h42);
    send(64'h8_0000_0100, 1'b0, 64'd0);
    tick();
    chk("dm_old_offset", dm_req_addr, 64'h100);
    tick();
    dm_bottom = 64'h8_0000_0100; cfg_load = 1'b1;
    tick();
    cfg_load = 1'b0;
    chk("pend_ready_wait", 64'(req_ready), 64'd0);
    dm_rsp_valid = 1'b1; dm_rsp_rdata = 64'h42;
    tick();
    dm_rsp_valid = 1'b0;
    chk("pend_ready_resp", 64'(req_ready), 64'd0);
    tick();
    chk("pend_ready_idle", 64'(req_ready), 64'd0);
    tick();
    push(1'b0, 64'h43);
    send(64'h8_0000_0100, 1'b0, 64'd0);
    tick();
    chk("dm_new_offset", dm_req_addr, 64'h0);
    tick();
    dm_rsp_valid = 1'b1; dm_rsp_rdata = 64'h43;
    tick();
    dm_rsp_valid = 1'b0;
    tick();
    dm_req_ready = 1'b0;

    // reset in WAIT_IM abandons the transaction
    im_req_ready = 1'b1;
    send(64'h1F08, 1'b0, 64'd0);
    tick(); tick();
    snap_rsp = rsp_cnt;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rstmid_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rstmid_im_valid", 64'(im_req_valid), 64'd0);
    chk("rstmid_im_addr", im_req_addr, 64'd0);
    chk("rstmid_req_ready", 64'(req_ready), 64'd0);
    chk("rstmid_fault", 64'(fault), 64'd0);
`ifdef CPU_MEM_REGION_FAULT_LOG_EN
    chk("rstmid_fault_count", 64'(fault_count), 64'd0);
`endif
    im_rsp_valid = 1'b1; im_rsp_rdata = 64'h99;
    tick();
    im_rsp_valid = 1'b0;
    tick();
    chk("rstmid_no_rsp", 64'(rsp_cnt - snap_rsp), 64'd0);
    chk("rstmid_still_not_ready", 64'(req_ready), 64'd0);
    set_default_bounds();
    cfg_load = 1'b1; tick(); cfg_load = 1'b0;
    push(1'b0, 64'h1234);
    send(64'h1F10, 1'b0, 64'd0);
    tick();
    chk("reload_im_offset", im_req_addr, 64'h10);
    tick();
    im_rsp_valid = 1'b1; im_rsp_rdata = 64'h1234;
    tick();
    im_rsp_valid = 1'b0;
    tick(); tick();
    im_req_ready = 1'b0;

    chk("scoreboard_drained", 64'(sbq.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
